// File: rtl/meas_bcd_fmt_pkg.sv
// Shared types and widths for the measurement BCD formatter.
// State encoding plus binary/BCD widths of the two result paths.
package meas_bcd_fmt_pkg;

   localparam int FREQ_BITS   = 20;
   localparam int FREQ_DIGITS = 7;
   localparam int MV_BITS     = 16;
   localparam int MV_DIGITS   = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_CONV_F = 3'd2,
      ST_CONV_V = 3'd3,
      ST_DONE   = 3'd4
   } fmt_state_e;

endpackage

// File: rtl/meas_bcd_fmt_bcd_dd_step.sv
// One double-dabble iteration: add 3 to nibbles >= 5, then shift
// the {bcd, bin} pair left by one bit.
module bcd_dd_step #(
   parameter int DIGITS = 7,
   parameter int BITS   = 20
) (
   input  logic [4*DIGITS-1:0] bcd_cur,
   input  logic [BITS-1:0]     bin_cur,
   output logic [4*DIGITS-1:0] bcd_nxt,
   output logic [BITS-1:0]     bin_nxt
);

   logic [4*DIGITS-1:0] bcd_adj;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = (bcd_cur[4*i +: 4] >= 4'd5)
                               ? bcd_cur[4*i +: 4] + 4'd3
                               : bcd_cur[4*i +: 4];
   end

   assign bcd_nxt = {bcd_adj[4*DIGITS-2:0], bin_cur[BITS-1]};
   assign bin_nxt = {bin_cur[BITS-2:0], 1'b0};

   // Top bit always shifts out as 0 when the digit count suffices.
   logic unused_msb;
   assign unused_msb = bcd_adj[4*DIGITS-1];

endmodule

// File: rtl/meas_bcd_fmt.sv
// Periodic snapshot of frequency and Vpp, mV scaling, and sequential
// binary-to-BCD conversion with an atomic result update and done strobe.
module meas_bcd_fmt
   import meas_bcd_fmt_pkg::*;
#(
   parameter logic [23:0] UPDATE_CNT = 24'd10_000_000,
   parameter logic [13:0] VPP_SCALE  = 14'd10039
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic [19:0] ad_freq,
   input  logic [7:0]  ad_vpp,
   output logic [27:0] freq_bcd,
   output logic [15:0] vpp_mv,
   output logic [19:0] vpp_bcd,
   output logic        fmt_done,
   output logic        busy
);

   fmt_state_e state;

   logic [23:0] cnt;
   logic        tick;

   logic [FREQ_BITS-1:0]     snap_f;
   logic [7:0]               snap_v;
   logic [MV_BITS-1:0]       mv;
   logic [4:0]               iter;

   logic [FREQ_BITS-1:0]     f_bin, f_bin_nxt;
   logic [4*FREQ_DIGITS-1:0] f_bcd, f_bcd_nxt;
   logic [MV_BITS-1:0]       v_bin, v_bin_nxt;
   logic [4*MV_DIGITS-1:0]   v_bcd, v_bcd_nxt;

   logic [21:0] prod;
   logic        match;

   assign tick  = (cnt == UPDATE_CNT - 24'd1);
   assign prod  = {14'd0, snap_v} * {8'd0, VPP_SCALE};
   assign match = (ad_freq == snap_f) && (ad_vpp == snap_v);

   logic unused_frac;
   assign unused_frac = ^prod[7:0];

   bcd_dd_step #(.DIGITS(FREQ_DIGITS), .BITS(FREQ_BITS)) u_step_f (
      .bcd_cur (f_bcd),
      .bin_cur (f_bin),
      .bcd_nxt (f_bcd_nxt),
      .bin_nxt (f_bin_nxt)
   );

   bcd_dd_step #(.DIGITS(MV_DIGITS), .BITS(MV_BITS)) u_step_v (
      .bcd_cur (v_bcd),
      .bin_cur (v_bin),
      .bcd_nxt (v_bcd_nxt),
      .bin_nxt (v_bin_nxt)
   );

   always_ff @(posedge sys_clk) begin
      if (!rst_n || tick) cnt <= 24'd0;
      else                cnt <= cnt + 24'd1;
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         snap_f   <= '0;
         snap_v   <= '0;
         mv       <= '0;
         iter     <= '0;
         f_bin    <= '0;
         f_bcd    <= '0;
         v_bin    <= '0;
         v_bcd    <= '0;
         freq_bcd <= '0;
         vpp_mv   <= '0;
         vpp_bcd  <= '0;
         fmt_done <= 1'b0;
         busy     <= 1'b0;
      end else begin
         fmt_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               // busy stays up through the fmt_done cycle, drops here
               busy <= 1'b0;
               if (tick && !hold) begin
                  snap_f <= ad_freq;
                  snap_v <= ad_vpp;
                  busy   <= 1'b1;
                  state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (match) begin
                  mv    <= {2'b00, prod[21:8]};
                  f_bin <= snap_f;
                  f_bcd <= '0;
                  iter  <= '0;
                  state <= ST_CONV_F;
               end else begin
                  snap_f <= ad_freq;
                  snap_v <= ad_vpp;
               end
            end
            ST_CONV_F: begin
               f_bin <= f_bin_nxt;
               f_bcd <= f_bcd_nxt;
               iter  <= iter + 5'd1;
               if (iter == 5'd19) begin
                  v_bin <= mv;
                  v_bcd <= '0;
                  iter  <= '0;
                  state <= ST_CONV_V;
               end
            end
            ST_CONV_V: begin
               v_bin <= v_bin_nxt;
               v_bcd <= v_bcd_nxt;
               iter  <= iter + 5'd1;
               if (iter == 5'd15) state <= ST_DONE;
            end
            ST_DONE: begin
               freq_bcd <= f_bcd;
               vpp_mv   <= mv;
               vpp_bcd  <= v_bcd;
               fmt_done <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_meas_bcd_fmt.sv
// Directed bench for meas_bcd_fmt with a short snapshot period.
// Expected values are hand-computed decimal/BCD constants.
module tb_meas_bcd_fmt;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        hold;
   logic [19:0] ad_freq;
   logic [7:0]  ad_vpp;
   logic [27:0] freq_bcd;
   logic [15:0] vpp_mv;
   logic [19:0] vpp_bcd;
   logic        fmt_done;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 sys_clk = ~sys_clk;

   meas_bcd_fmt #(
      .UPDATE_CNT (24'd64),
      .VPP_SCALE  (14'd10039)
   ) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .hold     (hold),
      .ad_freq  (ad_freq),
      .ad_vpp   (ad_vpp),
      .freq_bcd (freq_bcd),
      .vpp_mv   (vpp_mv),
      .vpp_bcd  (vpp_bcd),
      .fmt_done (fmt_done),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic wait_busy(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge sys_clk);
         if (busy) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge sys_clk);
         if (fmt_done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic chk_res(input string tag, input logic [27:0] f,
                          input logic [15:0] m, input logic [19:0] v);
      chk({tag, "_freq"}, {4'd0, freq_bcd}, {4'd0, f});
      chk({tag, "_mv"},   {16'd0, vpp_mv},  {16'd0, m});
      chk({tag, "_vbcd"}, {12'd0, vpp_bcd}, {12'd0, v});
   endtask

   task automatic chk_zero(input string tag);
      chk_res(tag, 28'h0, 16'd0, 20'h0);
      chk({tag, "_done"}, {31'd0, fmt_done}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      int n2;
      int seen;
      rst_n   = 1'b0;
      hold    = 1'b0;
      ad_freq = 20'd1_000_000;
      ad_vpp  = 8'd255;
      repeat (3) @(negedge sys_clk);
      chk_zero("rst");
      rst_n = 1'b1;

      wait_busy(n);
      chk("first_tick", n, 64);
      wait_done(n);
      chk("lat_1m", n, 38);
      chk_res("1m", 28'h1000000, 16'd9999, 20'h09999);
      ad_freq = 20'hFFFFF;
      ad_vpp  = 8'd128;
      @(negedge sys_clk);
      chk("done_pulse", {31'd0, fmt_done}, 32'd0);
      chk("busy_drop", {31'd0, busy}, 32'd0);

      wait_busy(n);
      wait_done(n);
      chk("lat_max", n, 38);
      chk_res("max", 28'h1048575, 16'd5019, 20'h05019);
      ad_freq = 20'd0;
      ad_vpp  = 8'd1;

      wait_busy(n);
      wait_done(n);
      chk("lat_min", n, 38);
      chk_res("min", 28'h0, 16'd39, 20'h00039);
      ad_freq = 20'd500;
      ad_vpp  = 8'd10;

      wait_busy(n);
      ad_vpp = 8'd20;
      wait_done(n);
      chk("lat_retry", n, 39);
      chk_res("retry", 28'h0000500, 16'd784, 20'h00784);

      hold    = 1'b1;
      ad_freq = 20'd123;
      ad_vpp  = 8'd50;
      seen    = 0;
      repeat (80) begin
         @(negedge sys_clk);
         if (busy || fmt_done) seen++;
      end
      chk("hold_idle", seen, 0);
      chk_res("hold", 28'h0000500, 16'd784, 20'h00784);
      hold = 1'b0;

      wait_busy(n);
      repeat (10) @(negedge sys_clk);
      hold = 1'b1;
      wait_done(n2);
      chk("lat_hold_mid", n2 + 10, 38);
      chk_res("hmid", 28'h0000123, 16'd1960, 20'h01960);
      hold = 1'b0;

      wait_busy(n);
      repeat (19) @(negedge sys_clk);
      rst_n = 1'b0;
      @(negedge sys_clk);
      chk_zero("rst_mid");
      ad_freq = 20'd42;
      ad_vpp  = 8'd2;
      @(negedge sys_clk);
      rst_n = 1'b1;
      wait_busy(n);
      chk("tick_after_rst", n, 64);
      wait_done(n);
      chk("lat_after_rst", n, 38);
      chk_res("after_rst", 28'h0000042, 16'd78, 20'h00078);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
